pc_sequencer: RTL and testbench

- Program-counter stage directly downstream of the termination-detect logic.
- Consumes its freeze (ebreak) and reset_PC (ecall/fence) requests, plus stall and branch redirects.
- Owns the architectural PC register through a RUN/FLUSH/HALT state machine.
- Drives the instruction-fetch address and a pipeline flush strobe.

---
 rtl/pc_sequencer.sv | 214 +++++++++++++++++++++
 tb/tb_pc_sequencer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
//
// Program-counter stage that sits directly after the termination-detect logic.
// It owns the architectural PC and steps it through a RUN / FLUSH / HALT state
// machine. It acts on these requests:
//   - freeze (ebreak): halt with the PC still pointing at the ebreak.
//   - reset_PC (ecall/fence): flush the pipeline, then restart at RESET_VECTOR.
//   - stall: hold the PC.
//   - branch: redirect the PC.
//
// Optional feature (macro PC_PERF_CNT_EN):
//   When the macro is defined, cycle_cnt and instret_cnt are live performance
//   counters. When it is not defined, both ports are tied to zero and no
//   counter flops exist.
//
// Parameters:
//   XLEN          PC width in bits
//   RESET_VECTOR  PC loaded on rst and at the end of a restart
//   FLUSH_CYCLES  cycles of flush before a restart (0..15)
//
// Ports:
//   clk            in   rising-edge clock
//   rst            in   asynchronous, active-low reset
//   freeze         in   ebreak detected for the instruction at pc
//   reset_PC       in   ecall/fence detected for the instruction at pc
//   resume         in   leave HALT (single-cycle pulse)
//   stall          in   hold pc this cycle
//   branch_taken   in   redirect request
//   branch_target  in   redirect address (XLEN)
//   pc             out  fetch address, registered (XLEN)
//   pc_valid       out  pc is a live fetch (state RUN), decoded from state
//   flush          out  kill in-flight pipeline instructions, registered
//   halted         out  state HALT, decoded from state
//   misaligned     out  sticky: a taken branch had target[1:0] != 0
//   cycle_cnt      out  cycles spent outside HALT (32)
//   instret_cnt    out  RUN cycles in which pc advanced (32)
//   state_dbg      out  raw FSM state, for observation only
//
// Handshake note: every request input is a level sampled on the rising edge.
// There is no ready/acknowledge. A request that is dropped stays dropped. For
// example, a branch presented during a stall is ignored, and the requester
// must assert it again in a later cycle.
// -----------------------------------------------------------------------------
module pc_sequencer #(
  parameter int unsigned           XLEN         = 32,
  parameter logic [XLEN-1:0]       RESET_VECTOR = {XLEN{1'b0}},
  parameter int unsigned           FLUSH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            freeze,
  input  logic            reset_PC,
  input  logic            resume,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  output logic [XLEN-1:0] pc,
  output logic            pc_valid,
  output logic            flush,
  output logic            halted,
  output logic            misaligned,
  output logic [31:0]     cycle_cnt,
  output logic [31:0]     instret_cnt,
  output logic [1:0]      state_dbg
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  // The flush counter is loaded with FLUSH_CYCLES-1. The cycle that sees
  // cnt==0 is the last FLUSH cycle, so FLUSH lasts exactly FLUSH_CYCLES cycles.
  localparam logic [3:0] FLUSH_LOAD =
    (FLUSH_CYCLES == 0) ? 4'd0 : 4'(FLUSH_CYCLES - 1);

  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  state_t          state;
  logic [3:0]      cnt;
  logic [XLEN-1:0] pc_inc;
  logic [XLEN-1:0] br_aligned;

  // The increment wraps modulo 2^XLEN on its own; no flag is raised.
  assign pc_inc     = pc + PC_STEP;
  assign br_aligned = {branch_target[XLEN-1:2], 2'b00};

  // These outputs decode the state register directly, with no extra flop.
  assign pc_valid  = (state == ST_RUN);
  assign halted    = (state == ST_HALT);
  assign state_dbg = state;

  // ---------------------------------------------------------------------------
  // Main FSM. Holds the PC, the flush strobe, the sticky misaligned flag and
  // the flush counter.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_RUN;
      pc         <= RESET_VECTOR;
      flush      <= 1'b0;
      misaligned <= 1'b0;
      cnt        <= 4'd0;
    end else begin
      case (state)
        ST_RUN: begin
          if (reset_PC) begin
            // reset_PC outranks freeze when both arrive in the same cycle.
            if (FLUSH_CYCLES == 0) begin
              // With no flush window, load the vector at once. Flush still
              // pulses so the pipeline drops the ecall/fence.
              pc    <= RESET_VECTOR;
              flush <= 1'b1;
            end else begin
              state <= ST_FLUSH;
              cnt   <= FLUSH_LOAD;
              flush <= 1'b1;
            end
          end else if (freeze) begin
            // PC keeps pointing at the ebreak. Any resume in this same cycle is
            // dropped because it is only looked at once the FSM is in HALT.
            state <= ST_HALT;
            flush <= 1'b1;
          end else if (stall) begin
            // A branch in this cycle is dropped; the requester re-asserts it.
            flush <= 1'b0;
          end else if (branch_taken) begin
            pc    <= br_aligned;
            flush <= 1'b1;
            if (branch_target[1:0] != 2'b00) begin
              misaligned <= 1'b1;
            end
          end else begin
            pc    <= pc_inc;
            flush <= 1'b0;
          end
        end

        ST_FLUSH: begin
          // Only rst can interrupt the flush window.
          if (cnt == 4'd0) begin
            pc    <= RESET_VECTOR;
            state <= ST_RUN;
            flush <= 1'b0;
          end else begin
            cnt   <= cnt - 4'd1;
            flush <= 1'b1;
          end
        end

        ST_HALT: begin
          // Flush is only a pulse on the entry cycle. Every input except
          // resume is ignored here.
          flush <= 1'b0;
          if (resume) begin
            pc    <= pc_inc;
            state <= ST_RUN;
          end
        end

        default: begin
          state <= ST_RUN;
          flush <= 1'b0;
        end
      endcase
    end
  end

`ifdef PC_PERF_CNT_EN
  // ---------------------------------------------------------------------------
  // Performance counters.
  // instret_cnt counts a RUN cycle in which pc takes a new value: a sequential
  // step, a branch redirect, or a vector load. The restart load that ends
  // FLUSH also counts. Stalls, the freeze cycle and a deferred reset_PC do not
  // count, and neither does any cycle spent in HALT.
  // ---------------------------------------------------------------------------
  logic advance;

  always_comb begin
    advance = 1'b0;
    case (state)
      ST_RUN: begin
        if (reset_PC) begin
          advance = (FLUSH_CYCLES == 0);
        end else begin
          advance = !freeze && !stall;
        end
      end
      ST_FLUSH: advance = (cnt == 4'd0);
      default:  advance = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_cnt   <= 32'd0;
      instret_cnt <= 32'd0;
    end else begin
      if (state != ST_HALT) begin
        cycle_cnt <= cycle_cnt + 32'd1;
      end
      if (advance) begin
        instret_cnt <= instret_cnt + 32'd1;
      end
    end
  end
`else
  assign cycle_cnt   = 32'd0;
  assign instret_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pc_sequencer
//
// Directed bench for pc_sequencer.
//   dut  : FLUSH_CYCLES = 2. Receives the full stimulus sequence.
//   dut0 : FLUSH_CYCLES = 0. Only its reset_PC input is driven; it shares
//          clk and rst with dut.
//
// Each step drives the inputs and pushes the expected
// {pc, pc_valid, flush, halted, misaligned} onto the scoreboard queue. The
// value is popped and compared 1 ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_pc_sequencer;

`ifdef PC_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // ---------------- dut signals ----------------
  logic        freeze = 1'b0, reset_PC = 1'b0, resume = 1'b0;
  logic        stall = 1'b0, branch_taken = 1'b0;
  logic [31:0] branch_target = 32'd0;
  logic [31:0] pc, cycle_cnt, instret_cnt;
  logic        pc_valid, flush, halted, misaligned;
  logic [1:0]  state_dbg;

  // ---------------- dut0 signals ----------------
  logic        reset_pc0 = 1'b0;
  logic        tie0 = 1'b0;
  logic [31:0] tie0_w = 32'd0;
  logic [31:0] pc0, cycle_cnt0, instret_cnt0;
  logic        pc_valid0, flush0, halted0, misaligned0;
  logic [1:0]  state_dbg0;

  pc_sequencer #(.XLEN(32), .RESET_VECTOR(32'h0), .FLUSH_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .reset_PC(reset_PC),
    .resume(resume), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .pc(pc), .pc_valid(pc_valid),
    .flush(flush), .halted(halted), .misaligned(misaligned),
    .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt), .state_dbg(state_dbg)
  );

  pc_sequencer #(.XLEN(32), .RESET_VECTOR(32'h0), .FLUSH_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .freeze(tie0), .reset_PC(reset_pc0),
    .resume(tie0), .stall(tie0), .branch_taken(tie0),
    .branch_target(tie0_w), .pc(pc0), .pc_valid(pc_valid0),
    .flush(flush0), .halted(halted0), .misaligned(misaligned0),
    .cycle_cnt(cycle_cnt0), .instret_cnt(instret_cnt0), .state_dbg(state_dbg0)
  );

  // ---------------- scoreboard ----------------
  logic [35:0] exp_q[$];
  int n_pass  = 0;
  int n_total = 0;

  function automatic logic [35:0] pk(input logic [31:0] p, input logic v,
                                     input logic f, input logic h,
                                     input logic m);
    return {p, v, f, h, m};
  endfunction

  task automatic check(input string tag, input logic [35:0] got,
                       input logic [35:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, got, exp);
  endtask

  // ---------------- driver ----------------
  // One clock edge per call. The result is checked 1 ns after the edge.
  task automatic step(input string tag, input logic fz, input logic rp,
                      input logic rs, input logic st, input logic bt,
                      input logic [31:0] tgt, input logic [35:0] exp);
    @(negedge clk);
    freeze        = fz;
    reset_PC      = rp;
    resume        = rs;
    stall         = st;
    branch_taken  = bt;
    branch_target = tgt;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    check(tag, {pc, pc_valid, flush, halted, misaligned}, exp_q.pop_front());
  endtask

  // ---------------- directed sequence ----------------
  logic [31:0] exp_pc;
  logic        st_i;

  initial begin
    // Reset values, sampled while rst is held low.
    @(posedge clk);
    #1;
    check("rst_pc",   {4'd0, pc},                  {4'd0, 32'h0});
    check("rst_flag", {33'd0, flush, halted, misaligned}, 36'd0);
    check("rst_cyc",  {4'd0, cycle_cnt},           36'd0);
    check("rst_ins",  {4'd0, instret_cnt},         36'd0);
    rst = 1'b1;

    // Sequential fetch, then freeze at pc=8.
    step("run4",  0,0,0,0,0, 32'h0, pk(32'h4, 1,0,0,0));
    step("run8",  0,0,0,0,0, 32'h0, pk(32'h8, 1,0,0,0));
    step("freeze",1,0,0,0,0, 32'h0, pk(32'h8, 0,1,1,0));
    // In HALT every input other than resume is ignored.
    step("halt_idle", 0,0,0,0,0, 32'h0,  pk(32'h8, 0,0,1,0));
    step("halt_rpc",  0,1,0,0,0, 32'h0,  pk(32'h8, 0,0,1,0));
    step("halt_br",   0,0,0,0,1, 32'h40, pk(32'h8, 0,0,1,0));
    step("halt_stl",  0,0,0,1,0, 32'h0,  pk(32'h8, 0,0,1,0));
    step("halt_fz",   1,0,0,0,0, 32'h0,  pk(32'h8, 0,0,1,0));
    step("resume",    0,0,1,0,0, 32'h0,  pk(32'hC, 1,0,0,0));
    step("run16",     0,0,0,0,0, 32'h0,  pk(32'h10,1,0,0,0));

    // reset_PC at pc=16: exactly two flush cycles, then restart at 0.
    step("rpc_enter", 0,1,0,0,0, 32'h0,  pk(32'h10,0,1,0,0));
    step("flush_2",   1,0,1,0,1, 32'h80, pk(32'h10,0,1,0,0));
    step("restart",   0,0,0,0,0, 32'h0,  pk(32'h0, 1,0,0,0));
    step("run4b",     0,0,0,0,0, 32'h0,  pk(32'h4, 1,0,0,0));

    // Branch to a misaligned target: first under stall, then for real.
    step("br_stall",  0,0,0,1,1, 32'h102, pk(32'h4,  1,0,0,0));
    step("br_mis",    0,0,0,0,1, 32'h102, pk(32'h100,1,1,0,1));
    step("mis_stick", 0,0,0,0,0, 32'h0,   pk(32'h104,1,0,0,1));

    // Wrap at 2^32.
    step("br_high", 0,0,0,0,1, 32'hFFFF_FFF8, pk(32'hFFFF_FFF8,1,1,0,1));
    step("wrap1",   0,0,0,0,0, 32'h0, pk(32'hFFFF_FFFC,1,0,0,1));
    step("wrap2",   0,0,0,0,0, 32'h0, pk(32'h0,        1,0,0,1));
    step("wrap3",   0,0,0,0,0, 32'h0, pk(32'h4,        1,0,0,1));

    // freeze with reset_PC: reset_PC wins and the FSM enters FLUSH.
    step("fz_rpc",  1,1,0,0,0, 32'h0, pk(32'h4, 0,1,0,1));
    // Asynchronous reset in the middle of FLUSH.
    freeze   = 1'b0;
    reset_PC = 1'b0;
    rst      = 1'b0;
    #1;
    check("rstf_pc",   {4'd0, pc}, {4'd0, 32'h0});
    check("rstf_flag", {33'd0, flush, halted, misaligned}, 36'd0);
    rst = 1'b1;

    // Counters: 10 RUN cycles, 2 of them stalled.
    exp_pc = 32'h0;
    for (int i = 0; i < 10; i++) begin
      st_i   = (i == 3) || (i == 7);
      exp_pc = st_i ? exp_pc : exp_pc + 32'd4;
      step("perf_run", 0,0,0,st_i,0, 32'h0, pk(exp_pc, 1,0,0,0));
    end
    check("cyc10", {4'd0, cycle_cnt},   {4'd0, PERF ? 32'd10 : 32'd0});
    check("ins8",  {4'd0, instret_cnt}, {4'd0, PERF ? 32'd8  : 32'd0});
    // The freeze cycle is still a RUN cycle, but pc does not advance in it.
    step("perf_fz", 1,0,0,0,0, 32'h0, pk(32'h20, 0,1,1,0));
    for (int i = 0; i < 3; i++) begin
      step("perf_halt", 0,0,0,0,0, 32'h0, pk(32'h20, 0,0,1,0));
    end
    check("cyc_halt", {4'd0, cycle_cnt},   {4'd0, PERF ? 32'd11 : 32'd0});
    check("ins_halt", {4'd0, instret_cnt}, {4'd0, PERF ? 32'd8  : 32'd0});

    // Asynchronous reset in the middle of HALT.
    rst = 1'b0;
    #1;
    check("rsth_pc",  {4'd0, pc}, {4'd0, 32'h0});
    check("rsth_flag",{33'd0, flush, halted, misaligned}, 36'd0);
    check("rsth_cyc", {4'd0, cycle_cnt}, 36'd0);
    rst = 1'b1;

    // FLUSH_CYCLES=0 instance: reset_PC loads the vector on the next edge.
    step("p4",  0,0,0,0,0, 32'h0, pk(32'h4, 1,0,0,0));
    check("fc0_4", pk(pc0, pc_valid0, flush0, halted0, misaligned0),
          pk(32'h4, 1,0,0,0));
    step("p8",  0,0,0,0,0, 32'h0, pk(32'h8, 1,0,0,0));
    check("fc0_8", pk(pc0, pc_valid0, flush0, halted0, misaligned0),
          pk(32'h8, 1,0,0,0));
    reset_pc0 = 1'b1;
    step("p12", 0,0,0,0,0, 32'h0, pk(32'hC, 1,0,0,0));
    check("fc0_rpc", pk(pc0, pc_valid0, flush0, halted0, misaligned0),
          pk(32'h0, 1,1,0,0));
    reset_pc0 = 1'b0;
    step("p16", 0,0,0,0,0, 32'h0, pk(32'h10,1,0,0,0));
    check("fc0_after", pk(pc0, pc_valid0, flush0, halted0, misaligned0),
          pk(32'h4, 1,0,0,0));

    // ---------------- final report ----------------
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
